// File: rtl/pkt_fifo_wr_arbiter.sv
// Write-side scheduler for the async packet FIFO: round-robin grants one whole packet per source,
// gates admission on AlmostFull, and truncates packets longer than c_MAX_PKT_LEN beats.
module pkt_fifo_wr_arbiter #(
  parameter int unsigned  c_NUM_SRC     = 4,
  parameter int unsigned  c_DATA_WIDTH  = 10,
  parameter int unsigned  c_MAX_PKT_LEN = 64,
  parameter int unsigned  c_CNT_WIDTH   = 16,
  localparam int unsigned c_GNT_WIDTH   = $clog2(c_NUM_SRC)
) (
  input  logic                              WrClock,
  input  logic                              Reset,
  input  logic [c_NUM_SRC-1:0]              src_valid,
  input  logic [c_NUM_SRC*c_DATA_WIDTH-1:0] src_data,
  input  logic [c_NUM_SRC-1:0]              src_eop,
  output logic [c_NUM_SRC-1:0]              src_ready,
  input  logic                              fifo_almost_full,
  output logic [c_DATA_WIDTH-1:0]           fifo_data,
  output logic                              fifo_wr_en,
  output logic                              fifo_wr_eop,
  output logic [c_GNT_WIDTH-1:0]            grant,
  output logic                              busy,
  output logic [c_CNT_WIDTH-1:0]            pkt_count,
  output logic [c_CNT_WIDTH-1:0]            trunc_count
);

  localparam int unsigned c_BEAT_WIDTH = $clog2(c_MAX_PKT_LEN + 1);
  localparam logic [c_BEAT_WIDTH-1:0] c_LAST_BEAT = c_BEAT_WIDTH'(c_MAX_PKT_LEN - 1);

  typedef enum logic [1:0] {StIdle, StXfer, StDrain} state_e;

  state_e                    state_q, state_d;
  logic [c_GNT_WIDTH-1:0]    grant_q, grant_d;
  logic [c_GNT_WIDTH-1:0]    rr_q, rr_d;
  logic [c_BEAT_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
  logic                      wr_en_q, wr_en_d;
  logic                      wr_eop_q, wr_eop_d;
  logic [c_DATA_WIDTH-1:0]   data_q, data_d;
  logic [c_CNT_WIDTH-1:0]    pkt_cnt_q, pkt_cnt_d;
  logic [c_CNT_WIDTH-1:0]    trunc_cnt_q, trunc_cnt_d;

  logic [c_DATA_WIDTH-1:0]   src_beat [c_NUM_SRC];
  logic [c_GNT_WIDTH-1:0]    scan_idx;
  logic [c_GNT_WIDTH-1:0]    arb_sel;
  logic                      arb_found;
  logic [c_GNT_WIDTH-1:0]    rr_next;
  logic                      beat_acc;
  logic                      grant_eop;

  for (genvar g = 0; g < c_NUM_SRC; g++) begin : g_beat
    assign src_beat[g] = src_data[g*c_DATA_WIDTH +: c_DATA_WIDTH];
  end

  // First valid source at or after the round-robin pointer, wrapping modulo c_NUM_SRC.
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < c_NUM_SRC; i++) begin
      scan_idx = c_GNT_WIDTH'((32'(rr_q) + i) % c_NUM_SRC);
      if (!arb_found && src_valid[scan_idx]) begin
        arb_found = 1'b1;
        arb_sel   = scan_idx;
      end
    end
  end

  always_comb begin
    src_ready = '0;
    if (state_q != StIdle) begin
      src_ready[grant_q] = 1'b1;
    end
  end

  assign beat_acc  = src_valid[grant_q] & src_ready[grant_q];
  assign grant_eop = src_eop[grant_q];
  assign rr_next   = c_GNT_WIDTH'((32'(grant_q) + 32'd1) % c_NUM_SRC);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    beat_cnt_d  = beat_cnt_q;
    wr_en_d     = 1'b0;
    wr_eop_d    = 1'b0;
    data_d      = data_q;
    pkt_cnt_d   = pkt_cnt_q;
    trunc_cnt_d = trunc_cnt_q;
    case (state_q)
      StIdle: begin
        if (arb_found && !fifo_almost_full) begin
          grant_d    = arb_sel;
          beat_cnt_d = '0;
          state_d    = StXfer;
        end
      end
      StXfer: begin
        if (beat_acc) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          wr_en_d    = 1'b1;
          data_d     = src_beat[grant_q];
          if (grant_eop) begin
            wr_eop_d  = 1'b1;
            pkt_cnt_d = pkt_cnt_q + 1'b1;
            rr_d      = rr_next;
            state_d   = StIdle;
          end else if (beat_cnt_q == c_LAST_BEAT) begin
            // Close the packet in the FIFO now; the rest of it is swallowed in StDrain.
            wr_eop_d    = 1'b1;
            pkt_cnt_d   = pkt_cnt_q + 1'b1;
            trunc_cnt_d = trunc_cnt_q + 1'b1;
            state_d     = StDrain;
          end
        end
      end
      StDrain: begin
        if (beat_acc && grant_eop) begin
          rr_d    = rr_next;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge WrClock or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      rr_q        <= '0;
      beat_cnt_q  <= '0;
      wr_en_q     <= 1'b0;
      wr_eop_q    <= 1'b0;
      data_q      <= '0;
      pkt_cnt_q   <= '0;
      trunc_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      beat_cnt_q  <= beat_cnt_d;
      wr_en_q     <= wr_en_d;
      wr_eop_q    <= wr_eop_d;
      data_q      <= data_d;
      pkt_cnt_q   <= pkt_cnt_d;
      trunc_cnt_q <= trunc_cnt_d;
    end
  end

  assign fifo_data   = data_q;
  assign fifo_wr_en  = wr_en_q;
  assign fifo_wr_eop = wr_eop_q;
  assign grant       = grant_q;
  assign busy        = (state_q != StIdle);
  assign pkt_count   = pkt_cnt_q;
  assign trunc_count = trunc_cnt_q;

endmodule
